// File: rtl/result_checker.sv
// Readback/compare engine: streams N result words and N golden words out of two
// registered-read SRAMs, counts equal and unequal pairs, and records the result
// address of the first unequal pair.
// Latency: busy is high for N+1 cycles; word i is compared two edges after its address.
// Backpressure: none; one address pair is issued per cycle, and run is a level
// that is ignored while busy.
// Ports: clock/reset_b; run/busy handshake; num_results, result_base and
// golden_base are sampled at start; read_address_*/read_data_* form the two SRAM
// read ports; correct_count, mismatch_count and first_mismatch_* are the results.
module result_checker #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 13
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  run,
  output logic                  busy,
  input  logic [CNT_WIDTH-1:0]  num_results,
  input  logic [ADDR_WIDTH-1:0] result_base,
  input  logic [ADDR_WIDTH-1:0] golden_base,
  output logic [ADDR_WIDTH-1:0] read_address_results,
  input  logic [DATA_WIDTH-1:0] read_data_results,
  output logic [ADDR_WIDTH-1:0] read_address_golden,
  input  logic [DATA_WIDTH-1:0] read_data_golden,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  first_mismatch_valid,
  output logic [ADDR_WIDTH-1:0] first_mismatch_address
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;        // index of the next address to issue
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0] gaddr_q, gaddr_d;
  logic                  vld1_q, vld1_d;      // address registered this cycle
  logic                  vld2_q, vld2_d;      // SRAM data for that address is valid
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;  // result address that goes with vld2
  logic [CNT_WIDTH-1:0]  correct_q, correct_d;
  logic [CNT_WIDTH-1:0]  mismatch_q, mismatch_d;
  logic                  fmv_q, fmv_d;
  logic [ADDR_WIDTH-1:0] fma_q, fma_d;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    n_d        = n_q;
    idx_d      = idx_q;
    raddr_d    = raddr_q;
    gaddr_d    = gaddr_q;
    vld1_d     = 1'b0;
    vld2_d     = vld1_q;
    cmp_addr_d = raddr_q;
    correct_d  = correct_q;
    mismatch_d = mismatch_q;
    fmv_d      = fmv_q;
    fma_d      = fma_q;

    // Compare stage. The data is looked at only when vld2 is set, so X on an
    // idle read port cannot disturb the counts.
    if (vld2_q) begin
      if (read_data_results == read_data_golden) begin
        correct_d = correct_q + CNT_WIDTH'(1);
      end else begin
        mismatch_d = mismatch_q + CNT_WIDTH'(1);
        if (!fmv_q) begin
          fmv_d = 1'b1;
          fma_d = cmp_addr_q;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (run) begin
          busy_d     = 1'b1;
          n_d        = num_results;
          correct_d  = '0;
          mismatch_d = '0;
          fmv_d      = 1'b0;
          fma_d      = '0;
          if (num_results == '0) begin
            // Nothing to read. busy is held for the one cycle that HOLD needs to clear it.
            state_d = HOLD;
          end else begin
            // Index 0 is issued on the start edge itself.
            raddr_d = result_base;
            gaddr_d = golden_base;
            vld1_d  = 1'b1;
            idx_d   = CNT_WIDTH'(1);
            state_d = (num_results == CNT_WIDTH'(1)) ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        // Incrementing the address registers wraps modulo 2^ADDR_WIDTH by construction.
        raddr_d = raddr_q + ADDR_WIDTH'(1);
        gaddr_d = gaddr_q + ADDR_WIDTH'(1);
        vld1_d  = 1'b1;
        idx_d   = idx_q + CNT_WIDTH'(1);
        if (idx_q == n_q - CNT_WIDTH'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last compare happens on this edge when the pipeline has only its tail left.
        if (vld2_q && !vld1_q) begin
          state_d = HOLD;
          busy_d  = 1'b0;
        end
      end
      HOLD: begin
        busy_d = 1'b0;
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      raddr_q    <= '0;
      gaddr_q    <= '0;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      cmp_addr_q <= '0;
      correct_q  <= '0;
      mismatch_q <= '0;
      fmv_q      <= 1'b0;
      fma_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      raddr_q    <= raddr_d;
      gaddr_q    <= gaddr_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      cmp_addr_q <= cmp_addr_d;
      correct_q  <= correct_d;
      mismatch_q <= mismatch_d;
      fmv_q      <= fmv_d;
      fma_q      <= fma_d;
    end
  end

  assign busy                   = busy_q;
  assign read_address_results   = raddr_q;
  assign read_address_golden    = gaddr_q;
  assign correct_count          = correct_q;
  assign mismatch_count         = mismatch_q;
  assign first_mismatch_valid   = fmv_q;
  assign first_mismatch_address = fma_q;

endmodule

// File: doc/result_checker.md
# result_checker

Hardware readback and compare engine for the output side of the accelerator. It is the reader for the results the compute core writes into the output SRAM. It is started with the same run/busy handshake the core uses, streams N result words from the output SRAM and N golden words from a golden SRAM, and reports match and mismatch counts plus the first failing address. It replaces the bench-side dump/compare flow, so rounds can be checked on silicon or in emulation without file I/O.

## Interface
- ADDR_WIDTH, 12, SRAM address width
- DATA_WIDTH, 16, SRAM word width
- CNT_WIDTH, 13, width of length and count fields (max 4096 words)

Ports:
- clock  in  1  single clock, rising edge
- reset_b  in  1  asynchronous, active-low reset
- run  in  1  start request; level, held until busy seen high
- busy  out  1  high while a check is in progress
- num_results  in  CNT_WIDTH  word count N; sampled at start
- result_base  in  ADDR_WIDTH  first output-SRAM address; sampled at start
- golden_base  in  ADDR_WIDTH  first golden-SRAM address; sampled at start
- read_address_results  out  ADDR_WIDTH  output-SRAM read address (registered)
- read_data_results  in  DATA_WIDTH  output-SRAM read data
- read_address_golden  out  ADDR_WIDTH  golden-SRAM read address (registered)
- read_data_golden  in  DATA_WIDTH  golden-SRAM read data
- correct_count  out  CNT_WIDTH  number of equal word pairs
- mismatch_count  out  CNT_WIDTH  number of unequal word pairs
- first_mismatch_valid  out  1  at least one mismatch seen this check
- first_mismatch_address  out  ADDR_WIDTH  result-SRAM address of the first mismatch

## Operation
- Both SRAMs have a registered read: the address is sampled at edge E, and the data is valid after E.
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE, run=1: enter FETCH.
  - Latch N and both bases.
  - Clear both counts, first_mismatch_valid and first_mismatch_address.
  - Set busy=1.
  - Address index i=0.
  - If N=0, go to HOLD instead; busy is then high for exactly one cycle.
- FETCH:
  - Each cycle, drive result_base+i and golden_base+i, then increment i.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - After issuing i=N-1, go to DRAIN.
- Compare pipeline:
  - A valid-shift register tracks each issued address.
  - Word i is compared at the edge two cycles after its address was registered.
  - Equal: correct_count+1. Unequal: mismatch_count+1.
  - On the first unequal word only, latch first_mismatch_address = result_base+i and set first_mismatch_valid=1.
- DRAIN:
  - Waits until the last compare retires, then goes to HOLD with busy=0.
- HOLD:
  - Results stay stable.
  - Returns to IDLE only once run=0 is sampled. A run still held high never restarts a check.
- Address outputs hold their last value outside FETCH.
- Counts do not saturate: N ≤ 4096 fits CNT_WIDTH.

## Timing
- Let E0 be the edge at which IDLE samples run=1.
- busy rises after E0.
- Address for index i is registered at E(i), for i = 0..N-1.
- Compare for index i occurs at E(i+2).
- busy falls at E(N+1), so busy is high for N+1 cycles. Counts are final when busy falls.
- Reset values (asynchronous, on reset_b=0): state IDLE; busy=0; both addresses 0; both counts 0; first_mismatch_valid=0; first_mismatch_address=0; pipeline valids cleared.
- Reset mid-check aborts immediately, with no partial result retained. After release the block is in IDLE and accepts run normally.
- run changes while busy=1 are ignored.
- Input data is sampled only when the pipeline valid is set. X on the read data at other times has no effect.

## Test plan
- Reset: assert reset_b=0 mid-cycle -> every output equals its reset value before the next edge.
- All match: result_base=0, golden_base=0, N=96, identical memories -> correct_count=96, mismatch_count=0, first_mismatch_valid=0, busy high exactly 97 cycles.
- Mismatches: N=144, words at indices 5 and 100 corrupted -> correct_count=142, mismatch_count=2, first_mismatch_address=0x005, first_mismatch_valid=1.
- Wrap: result_base=0xFFE, golden_base=0x010, N=4 -> result addresses 0xFFE, 0xFFF, 0x000, 0x001; golden addresses 0x010 to 0x013; correct_count=4.
- Handshake: hold run=1 through completion -> no second check. Drop run, then reassert -> new check with counts cleared. N=0 -> busy high one cycle, all counts 0.
- Abort: reset_b=0 during FETCH at i=50 of N=144 -> busy=0 and counts 0 immediately. After release, a run with N=144 and identical memories -> correct_count=144.
